// File: rtl/fc_pkg.sv
// Shared types and constants for the FC result sink: FSM state encoding,
// address/count widths and default ifmap buffer base addresses.
package fc_pkg;

    typedef enum logic [1:0] {
        FC_IDLE    = 2'd0,
        FC_COLLECT = 2'd1,
        FC_FLUSH   = 2'd2,
        FC_ISSUE   = 2'd3
    } fc_state_e;

    localparam int DATA_W    = 8;   // FC output beat width (signed, saturated)
    localparam int ADDR_W    = 10;  // ifmap buffer address width
    localparam int OUT_NUM_W = 7;   // output-node count width of a layer
    localparam int IN_NUM_W  = 9;   // input-node count width of the next layer
    localparam int LAYER_W   = 2;   // layer index width
    localparam int CNT_W     = OUT_NUM_W + 1;  // beat counter, one spare bit to see k >= N

    localparam int L2_BASE_DEF = 400;
    localparam int L3_BASE_DEF = 520;

endpackage

// File: rtl/fc_result_sink_if.sv
// FC output stream as seen by the result sink: one signed beat per valid
// cycle, a last marker, and the per-stream layer index / node count.
interface fc_result_sink_if;
    import fc_pkg::*;

    logic signed [DATA_W-1:0]    fc_result_i;
    logic                        fc_valid_i;
    logic                        fc_last_i;
    logic        [LAYER_W-1:0]   layer_i;
    logic        [OUT_NUM_W-1:0] out_num_i;

    // Producer side (FC engine or testbench)
    modport master (
        output fc_result_i, fc_valid_i, fc_last_i, layer_i, out_num_i
    );

    // Consumer side (result sink)
    modport slave (
        input fc_result_i, fc_valid_i, fc_last_i, layer_i, out_num_i
    );

endinterface

// File: rtl/fc_argmax.sv
// Running maximum with index for the final classification layer.
// The first beat of a stream always loads; later beats replace the held
// value only when strictly greater, so the lowest index wins ties.
// The post-update value is exposed combinationally so the caller can
// capture the result on the same edge as the last beat.
module fc_argmax
    import fc_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_clear,
    input  logic                        i_update,
    input  logic                        i_first,
    input  logic signed [DATA_W-1:0]    i_score,
    input  logic        [OUT_NUM_W-1:0] i_idx,
    output logic signed [DATA_W-1:0]    o_nxt_max,
    output logic        [OUT_NUM_W-1:0] o_nxt_idx
);

    logic signed [DATA_W-1:0]    r_max;
    logic        [OUT_NUM_W-1:0] r_idx;
    logic                        w_take;

    // Decide whether the incoming beat becomes the new maximum
    always_comb begin
        w_take    = i_first || (i_score > r_max);
        o_nxt_max = w_take ? i_score : r_max;
        o_nxt_idx = w_take ? i_idx   : r_idx;
    end

    // Hold the running maximum; clear has priority over update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_max <= '0;
            r_idx <= '0;
        end else if (i_clear) begin
            r_max <= '0;
            r_idx <= '0;
        end else if (i_update) begin
            r_max <= o_nxt_max;
            r_idx <= o_nxt_idx;
        end
    end

endmodule

// File: rtl/fc_result_sink.sv
// FC result sink: consumes one layer's output stream. Hidden layers are
// written (ReLU applied, reversed order) into the ifmap buffer and the next
// layer is kicked off; the final layer is reduced to an argmax class result.
// Beat-count violations raise a sticky error and suppress completion pulses.
module fc_result_sink
    import fc_pkg::*;
#(
    parameter int L2_BASE     = L2_BASE_DEF,
    parameter int L3_BASE     = L3_BASE_DEF,
    parameter int FINAL_LAYER = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    fc_result_sink_if.slave             fc,
    output logic                        ifmap_wren_o,
    output logic        [ADDR_W-1:0]    ifmap_wrptr_o,
    output logic        [DATA_W-1:0]    ifmap_wdata_o,
    output logic                        next_start_o,
    output logic        [LAYER_W-1:0]   next_layer_o,
    output logic        [IN_NUM_W-1:0]  next_in_num_o,
    output logic                        class_valid_o,
    output logic        [OUT_NUM_W-1:0] class_o,
    output logic signed [DATA_W-1:0]    class_score_o,
    output logic                        busy_o,
    output logic                        err_o
);

    localparam logic [1:0] ST_IDLE    = FC_IDLE;
    localparam logic [1:0] ST_COLLECT = FC_COLLECT;
    localparam logic [1:0] ST_FLUSH   = FC_FLUSH;
    localparam logic [1:0] ST_ISSUE   = FC_ISSUE;

    // Negative activations are clamped to zero before storage
    function automatic logic [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] x);
        return x[DATA_W-1] ? '0 : $unsigned(x);
    endfunction

    logic [1:0]                  r_state;
    logic [1:0]                  w_state_nxt;
    logic [CNT_W-1:0]            r_k;

    logic                        r_wren;
    logic [ADDR_W-1:0]           r_wrptr;
    logic [DATA_W-1:0]           r_wdata;
    logic                        r_next_start;
    logic [LAYER_W-1:0]          r_next_layer;
    logic [IN_NUM_W-1:0]         r_next_in_num;
    logic                        r_class_valid;
    logic [OUT_NUM_W-1:0]        r_class;
    logic signed [DATA_W-1:0]    r_class_score;
    logic                        r_err;

    logic                        w_accept;
    logic                        w_drop;
    logic                        w_last;
    logic                        w_final;
    logic                        w_in_range;
    logic                        w_count_ok;
    logic                        w_to_idle;
    logic [CNT_W-1:0]            w_n_ext;
    logic [OUT_NUM_W-1:0]        w_offset;
    logic [ADDR_W-1:0]           w_base;
    logic signed [DATA_W-1:0]    w_max_nxt;
    logic [OUT_NUM_W-1:0]        w_idx_nxt;

    // Beat classification against the current state and beat index
    always_comb begin
        w_accept   = fc.fc_valid_i && ((r_state == ST_IDLE) || (r_state == ST_COLLECT));
        w_drop     = fc.fc_valid_i && ((r_state == ST_FLUSH) || (r_state == ST_ISSUE));
        w_last     = w_accept && fc.fc_last_i;
        w_final    = (fc.layer_i == FINAL_LAYER[LAYER_W-1:0]);
        w_n_ext    = {1'b0, fc.out_num_i};
        w_in_range = (r_k < w_n_ext);
        w_count_ok = (r_k == (w_n_ext - CNT_W'(1)));
        // Results are stored in reverse node order: beat 0 lands at base+N-1
        w_offset   = fc.out_num_i - OUT_NUM_W'(1) - r_k[OUT_NUM_W-1:0];
        w_base     = (fc.layer_i == '0) ? ADDR_W'(L2_BASE) : ADDR_W'(L3_BASE);
    end

    // Next-state logic; a bad last beat abandons the stream straight to IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_COLLECT: begin
                if (w_accept) begin
                    if (!fc.fc_last_i)
                        w_state_nxt = ST_COLLECT;
                    else if (w_count_ok)
                        w_state_nxt = ST_FLUSH;
                    else
                        w_state_nxt = ST_IDLE;
                end
            end
            ST_FLUSH: w_state_nxt = w_final ? ST_IDLE : ST_ISSUE;
            ST_ISSUE: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        w_to_idle = (w_state_nxt == ST_IDLE);
    end

    fc_argmax u_argmax (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_to_idle),
        .i_update  (w_accept && w_final && w_in_range),
        .i_first   (r_k == '0),
        .i_score   (fc.fc_result_i),
        .i_idx     (r_k[OUT_NUM_W-1:0]),
        .o_nxt_max (w_max_nxt),
        .o_nxt_idx (w_idx_nxt)
    );

    // State register and beat counter (counter saturates so overruns stay visible)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_to_idle)
                r_k <= '0;
            else if (w_accept && (r_k != '1))
                r_k <= r_k + CNT_W'(1);
        end
    end

    // Ifmap writeback, one cycle behind the accepted in-range hidden-layer beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wren  <= 1'b0;
            r_wrptr <= '0;
            r_wdata <= '0;
        end else begin
            r_wren <= w_accept && w_in_range && !w_final;
            if (w_accept && w_in_range && !w_final) begin
                r_wrptr <= w_base + ADDR_W'(w_offset);
                r_wdata <= relu(fc.fc_result_i);
            end
        end
    end

    // Completion pulses: next-layer start from FLUSH, class result on a good last beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_next_start  <= 1'b0;
            r_next_layer  <= '0;
            r_next_in_num <= '0;
            r_class_valid <= 1'b0;
            r_class       <= '0;
            r_class_score <= '0;
        end else begin
            r_next_start  <= (r_state == ST_FLUSH) && !w_final;
            r_class_valid <= w_last && w_count_ok && w_final;
            if ((r_state == ST_FLUSH) && !w_final) begin
                r_next_layer  <= fc.layer_i + LAYER_W'(1);
                r_next_in_num <= IN_NUM_W'(fc.out_num_i);
            end
            if (w_last && w_count_ok && w_final) begin
                r_class       <= w_idx_nxt;
                r_class_score <= w_max_nxt;
            end
        end
    end

    // Sticky error: overrun beat, mis-counted last beat, or beat during FLUSH/ISSUE
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_err <= 1'b0;
        else if ((w_accept && !w_in_range) || (w_last && !w_count_ok) || w_drop)
            r_err <= 1'b1;
    end

    assign ifmap_wren_o  = r_wren;
    assign ifmap_wrptr_o = r_wrptr;
    assign ifmap_wdata_o = r_wdata;
    assign next_start_o  = r_next_start;
    assign next_layer_o  = r_next_layer;
    assign next_in_num_o = r_next_in_num;
    assign class_valid_o = r_class_valid;
    assign class_o       = r_class;
    assign class_score_o = r_class_score;
    assign busy_o        = (r_state != ST_IDLE);
    assign err_o         = r_err;

endmodule
